// File: rtl/sync_debounce_pkg.sv
// Shared limits, counter sizing and event encoding for the synchroniser/debounce bank.
package sync_debounce_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 8;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_RISE,
    EV_FALL,
    EV_GLITCH
  } sync_event_t;

  // One spare bit so the terminal count FILTER_CYCLES-1 always fits.
  function automatic int filter_cnt_width(int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/sync_debounce_channel.sv
// One channel: async-input flop chain, stability counter and registered events.
// Event registers exist only when SYNC_DEBOUNCE_EVENTS_EN is defined.
module sync_debounce_channel
  import sync_debounce_pkg::*;
#(
  parameter int   STAGES        = 3,
  parameter int   FILTER_CYCLES = 16,
  parameter logic INIT          = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic glitch
);

  localparam int               CNT_W    = filter_cnt_width(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain_p0;
  logic             sy;
  logic [CNT_W-1:0] cnt_p1;
  logic             differ;
  logic             accept;
  logic             reject;

  // Stage p0: synchroniser chain, bit 0 samples the raw input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_p0 <= {STAGES{INIT}};
    end else begin
      chain_p0 <= {chain_p0[STAGES-2:0], din};
    end
  end

  assign sy     = chain_p0[STAGES-1];
  assign differ = (sy != dout);
  assign accept = differ && (cnt_p1 == CNT_LAST);
  assign reject = !differ && (cnt_p1 != '0);

  // Stage p1: debounce counter and accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout   <= INIT;
      cnt_p1 <= '0;
    end else if (accept) begin
      dout   <= sy;
      cnt_p1 <= '0;
    end else if (differ) begin
      cnt_p1 <= cnt_p1 + 1'b1;
    end else begin
      cnt_p1 <= '0;
    end
  end

`ifdef SYNC_DEBOUNCE_EVENTS_EN
  sync_event_t ev_nxt;
  sync_event_t ev_p1;

  always_comb begin
    ev_nxt = EV_NONE;
    if (accept) begin
      ev_nxt = sy ? EV_RISE : EV_FALL;
    end else if (reject) begin
      ev_nxt = EV_GLITCH;
    end
  end

  // Stage p1: one event per channel per cycle, encoded so they are mutually exclusive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_p1 <= EV_NONE;
    end else begin
      ev_p1 <= ev_nxt;
    end
  end

  assign rise   = (ev_p1 == EV_RISE);
  assign fall   = (ev_p1 == EV_FALL);
  assign glitch = (ev_p1 == EV_GLITCH);
`else
  assign rise   = 1'b0;
  assign fall   = 1'b0;
  assign glitch = 1'b0;
`endif

endmodule

// File: rtl/sync_debounce_bank.sv
// WIDTH-channel synchroniser + debounce bank; per-channel logic lives in sync_debounce_channel.
// Optional rise/fall/glitch events are built only with SYNC_DEBOUNCE_EVENTS_EN defined.
module sync_debounce_bank
  import sync_debounce_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter int               STAGES        = 3,
  parameter int               FILTER_CYCLES = 16,
  parameter logic [WIDTH-1:0] INIT          = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] glitch
);

  if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("sync_debounce_bank: STAGES=%0d outside %0d..%0d",
           STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
  end

  if (FILTER_CYCLES < 1) begin : g_bad_filter
    $error("sync_debounce_bank: FILTER_CYCLES must be at least 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sync_debounce_channel #(
      .STAGES        (STAGES),
      .FILTER_CYCLES (FILTER_CYCLES),
      .INIT          (INIT[i])
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    (din[i]),
      .dout   (dout[i]),
      .rise   (rise[i]),
      .fall   (fall[i]),
      .glitch (glitch[i])
    );
  end

endmodule

// File: tb/tb_sync_debounce_bank.sv
// Bench for sync_debounce_bank: history-based reference model, per-cycle compare, directed + random stimulus.
module tb_sync_debounce_bank;

  localparam int         W    = 4;
  localparam int         ST   = 3;
  localparam int         F    = 4;
  localparam logic [3:0] INIT = 4'h0;
  localparam int         MAXN = 8192;
`ifdef SYNC_DEBOUNCE_EVENTS_EN
  localparam bit EV_EN = 1'b1;
`else
  localparam bit EV_EN = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] din   = 4'h0;
  logic [3:0] dout, rise, fall, glitch;
  logic [3:0] dout1, rise1, fall1, glitch1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sync_debounce_bank #(.WIDTH(W), .STAGES(ST), .FILTER_CYCLES(F), .INIT(INIT)) dut (
    .clk(clk), .rst_n(rst_n), .din(din),
    .dout(dout), .rise(rise), .fall(fall), .glitch(glitch)
  );

  sync_debounce_bank #(.WIDTH(W), .STAGES(ST), .FILTER_CYCLES(1), .INIT(INIT)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din),
    .dout(dout1), .rise(rise1), .fall(fall1), .glitch(glitch1)
  );

  task automatic chk(string nm, logic [3:0] act, logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at t=%0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_int(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] ev(logic [3:0] x);
    return EV_EN ? x : 4'h0;
  endfunction

  // Reference model: din history per edge since reset; sy is din delayed by ST edges.
  // A level is accepted once F consecutive post-acceptance samples differ from dout.
  logic [3:0] dh  [MAXN];
  logic [3:0] syh [MAXN];
  int         n;
  int         last_acc [W];
  logic [3:0] m_dout, m_rise, m_fall, m_glitch;
  logic [3:0] e1_dout, e1_rise, e1_fall;

  function automatic logic [3:0] din_at(int k);
    return (k < 0) ? INIT : dh[k];
  endfunction

  task automatic model_reset();
    n        = 0;
    m_dout   = INIT;
    m_rise   = 4'h0;
    m_fall   = 4'h0;
    m_glitch = 4'h0;
    for (int c = 0; c < W; c++) last_acc[c] = -1;
    e1_dout  = INIT;
    e1_rise  = 4'h0;
    e1_fall  = 4'h0;
  endtask

  task automatic model_step();
    logic [3:0] sy, nd, nr, nf, ng;
    int run;
    if (n >= MAXN) begin
      $display("FAIL model_history overflow at t=%0t: got %0d, expected < %0d", $time, n, MAXN);
      $fatal(1, "history overflow");
    end
    dh[n]  = din;
    sy     = din_at(n - ST);
    syh[n] = sy;
    nd = m_dout; nr = 4'h0; nf = 4'h0; ng = 4'h0;
    for (int c = 0; c < W; c++) begin
      if (sy[c] == m_dout[c]) begin
        if ((n - 1 > last_acc[c]) && (syh[n-1][c] != m_dout[c])) ng[c] = 1'b1;
      end else begin
        run = 0;
        for (int j = n; j > last_acc[c] && run < F && syh[j][c] != m_dout[c]; j--) run++;
        if (run == F) begin
          nd[c] = sy[c];
          nr[c] = sy[c];
          nf[c] = ~sy[c];
          last_acc[c] = n;
        end
      end
    end
    m_dout   = nd;
    m_rise   = nr;
    m_fall   = nf;
    m_glitch = ng;
    e1_dout  = din_at(n - ST);
    e1_rise  = din_at(n - ST) & ~din_at(n - ST - 1);
    e1_fall  = ~din_at(n - ST) & din_at(n - ST - 1);
    n++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  always @(negedge clk) begin
    chk("dout",    dout,    m_dout);
    chk("rise",    rise,    ev(m_rise));
    chk("fall",    fall,    ev(m_fall));
    chk("glitch",  glitch,  ev(m_glitch));
    chk("dout1",   dout1,   e1_dout);
    chk("rise1",   rise1,   ev(e1_rise));
    chk("fall1",   fall1,   ev(e1_fall));
    chk("glitch1", glitch1, 4'h0);
  end

  task automatic tick(int k);
    repeat (k) @(negedge clk);
  endtask

  int gl, rs, k;
  int hold [W];

  task automatic random_run(int cycles);
    for (int c = 0; c < cycles; c++) begin
      for (int b = 0; b < W; b++) begin
        if (hold[b] == 0) begin
          din[b]  = 1'($urandom_range(0, 1));
          hold[b] = $urandom_range(1, 8);
        end else begin
          hold[b]--;
        end
      end
      tick(1);
    end
  endtask

  initial begin
    for (int b = 0; b < W; b++) hold[b] = 0;

    // Reset with inputs high: nothing propagates, no events.
    din = 4'hF; rst_n = 1'b0;
    tick(3);
    chk("rst_dout", dout, 4'h0);
    chk("rst_rise", rise, 4'h0);
    rst_n = 1'b1;
    tick(3); chk("f1_before", dout1, 4'h0);
    tick(1); chk("f1_after",  dout1, 4'hF);
    tick(2); chk("rel_edge5_dout", dout, 4'h0);
    tick(1); chk("rel_edge6_dout", dout, 4'hF);
             chk("rel_edge6_rise", rise, ev(4'hF));
    tick(1); chk("rel_rise_1cyc",  rise, 4'h0);

    // Short pulse on channel 0 is rejected.
    din = 4'h0; tick(12);
    din = 4'h1; tick(2); din = 4'h0;
    gl = 0; rs = 0;
    for (int c = 0; c < 12; c++) begin
      tick(1);
      if (glitch[0]) gl++;
      if (rise != 4'h0 || dout[0]) rs++;
    end
    chk_int("glitch_once", gl, EV_EN ? 1 : 0);
    chk_int("glitch_no_rise", rs, 0);

    // Simultaneous rise and fall on different channels.
    din = 4'h8; tick(12);
    chk("simul_pre", dout, 4'h8);
    din = 4'h4; k = 0;
    while (k < 12 && dout == 4'h8) begin
      tick(1); k++;
    end
    chk_int("simul_latency", k, 7);
    chk("simul_dout", dout, 4'h4);
    chk("simul_rise", rise, ev(4'h4));
    chk("simul_fall", fall, ev(4'h8));

    // Chatter on channel 1, excursions of 3 cycles each.
    gl = 0; rs = 0;
    for (int c = 0; c < 52; c++) begin
      din = (c < 40 && (c / 3) % 2 == 0) ? 4'h6 : 4'h4;
      tick(1);
      if (glitch[1]) gl++;
      if (rise[1] || fall[1] || dout[1]) rs++;
    end
    chk_int("chatter_glitches", gl, EV_EN ? 7 : 0);
    chk_int("chatter_no_change", rs, 0);

    random_run(600);

    // Reset in the middle of filtering a new level.
    din = 4'h3; tick(12);
    chk("midrst_pre", dout, 4'h3);
    din = 4'h7; tick(5);
    #2 rst_n = 1'b0;
    #1 chk("midrst_async_dout", dout, 4'h0);
    chk("midrst_async_ev", rise | fall | glitch, 4'h0);
    chk("midrst_async_dout1", dout1, 4'h0);
    tick(3); rst_n = 1'b1;
    tick(3); chk("midrst_f1_before", dout1, 4'h0);
    tick(1); chk("midrst_f1_after",  dout1, 4'h7);
    tick(2); chk("midrst_edge5", dout, 4'h0);
    tick(1); chk("midrst_edge6", dout, 4'h7);
             chk("midrst_rise",  rise, ev(4'h7));

    random_run(400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sync_debounce_bank.md
# sync_debounce_bank

Parametrised multi-channel synchroniser with per-channel digital debounce and edge/glitch event outputs. It brings WIDTH asynchronous level inputs (buttons, straps, status pins, slow cross-domain flags) into the `clk` domain through a configurable-depth flop chain. It then accepts a new level only after it has been stable for FILTER_CYCLES consecutive cycles. It sits at the chip boundary or at slow-flag domain crossings, feeding control logic that needs clean, glitch-free levels and single-cycle change events.

## Interface
- WIDTH, 8: number of independent channels.
- STAGES, 3: synchroniser flops per channel; legal range 2..8.
- FILTER_CYCLES, 16: consecutive stable cycles required to accept a new level; minimum 1, where 1 means no filtering.
- INIT, '0: WIDTH-bit reset value of the sync chain and `dout`.
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  WIDTH  asynchronous level inputs, with no timing relationship to `clk`.
- dout  out  WIDTH  synchronised, debounced levels.
- rise  out  WIDTH  one-cycle pulse when `dout[i]` goes 0->1.
- fall  out  WIDTH  one-cycle pulse when `dout[i]` goes 1->0.
- glitch  out  WIDTH  one-cycle pulse when a pending change on channel i is rejected.

## Operation
- Per-channel chain `s[0..STAGES-1]`: `s[0]<=din[i]`, `s[k]<=s[k-1]`. All chain flops carry ASYNC_REG="TRUE". The chain output is `s[STAGES-1]`, called `sy`.
- Per-channel counter `cnt`, width $clog2(FILTER_CYCLES)+1. On each edge:
  - `sy==dout[i]` and `cnt!=0`: `cnt<=0`, `glitch[i]<=1`.
  - `sy==dout[i]` and `cnt==0`: idle, no event.
  - `sy!=dout[i]` and `cnt==FILTER_CYCLES-1`: `dout[i]<=sy`, `cnt<=0`, and `rise[i]` or `fall[i]<=1` according to the new level.
  - `sy!=dout[i]` otherwise: `cnt<=cnt+1`.
- `rise`, `fall` and `glitch` are registered and deassert on the next edge unless re-triggered. A channel never asserts more than one of them in the same cycle.
- Channels are fully independent. Simultaneous changes on any subset produce simultaneous, independent events.
- Reset (async assert, sync-safe deassert handled upstream):
  - chain = INIT, `dout` = INIT;
  - `cnt` = 0;
  - `rise`/`fall`/`glitch` = 0.
- Reset does not generate events. After reset, the first real mismatch between `din` and INIT passes through the normal filter.

## Timing
- Input sampling: a `din` change captured at edge E appears at `sy` after edge E+STAGES-1.
- Acceptance: `dout` and its rise/fall pulse update at edge E+STAGES-1+FILTER_CYCLES, provided `sy` stays stable. With the defaults this is 18 cycles, ±1 cycle of sampling uncertainty.
- Rejection: a pulse of P<FILTER_CYCLES cycles at `sy` asserts `glitch` at the edge where `sy` returns. `dout` is unchanged.
- FILTER_CYCLES=1: `dout` lags `sy` by exactly one cycle, and `glitch` can never assert.
- Toggle faster than the filter: the counter restarts on every return to `dout`. `dout` never changes, and one glitch pulse is produced per rejected excursion.
- Reset mid-filter: outputs go to their reset values immediately on `rst_n` low, and any partial count is discarded.

## Configuration
- SYNC_DEBOUNCE_EVENTS_EN:
  - Defined: `rise`/`fall`/`glitch` logic is built as described above.
  - Undefined: the three ports remain present but are tied to '0, and their registers are not instantiated. `dout` behaviour is identical in both builds.

## Structure
- Package `sync_debounce_pkg`:
  - localparam limits `SYNC_STAGES_MIN=2` and `SYNC_STAGES_MAX=8`;
  - function `filter_cnt_width(int cycles)`;
  - `typedef enum logic [1:0] {EV_NONE, EV_RISE, EV_FALL, EV_GLITCH} sync_event_t`, used for internal per-channel event encoding.
- Sub-module `sync_debounce_channel`: one chain, counter and event register, instantiated WIDTH times in a generate loop. The top level only splits and concatenates vectors and holds the parameter-range assertions, which are elaborate-time `$error` on an illegal STAGES or FILTER_CYCLES=0.

## Test plan
Default bench configuration: WIDTH=4, STAGES=3, FILTER_CYCLES=4, INIT=4'h0, events enabled. `din` changes on the negative edge of `clk`.
- Reset release: hold `din`=4'hF through reset -> during reset `dout`=0 and no events; after release, `dout`=4'hF at edge 6 after the first sampling edge, with `rise`=4'hF for exactly 1 cycle.
- Glitch reject: `din[0]`=1 for 2 cycles, then 0 -> `dout[0]` stays 0, `glitch`=4'h1 for one cycle, `rise`=0 throughout.
- Simultaneous channels: from `dout`=4'h8, drive `din`=4'h4 and hold -> on the same edge `dout`=4'h4, `rise`=4'h4 and `fall`=4'h8.
- Chatter: toggle `din[1]` every 3 cycles for 40 cycles -> `dout[1]` is constant, with one glitch pulse per excursion back to `dout[1]` and no rise/fall.
- Reset mid-filter: raise `din[2]`, then assert `rst_n` 5 cycles later -> `dout`=0 and `cnt`=0 immediately (asynchronously); after release with `din[2]` still 1, the full 6-cycle latency is observed again.
- Build variants:
  - FILTER_CYCLES=1: `dout` follows `din` with latency 3, and `glitch` is always 0.
  - Macro undefined: `rise`/`fall`/`glitch` are constant 0 while `dout` matches the events-enabled reference run cycle-for-cycle.
